// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare/gselect direction predictor.
// Build option: define GSHARE_HASH_EN to XOR the PC with the history
// (gshare); leave it undefined for the concatenated (gselect) index.
package bp_pkg;

    // Counter type at the default 2-bit width
    typedef logic [1:0] ctr_t;

    typedef enum logic {
        BP_INIT,
        BP_READY
    } bp_state_e;

    // Largest value a w-bit saturating counter can hold
    function automatic int unsigned ctr_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Smallest counter value that predicts taken
    function automatic int unsigned ctr_thresh(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    // PHT index from a PC and a zero-extended history, truncated to idx_w bits.
    // In concat mode, when ghr_len >= idx_w no PC bits survive the truncation.
    function automatic logic [31:0] bp_idx(input logic [31:0] pc,
                                           input logic [31:0] ghr,
                                           input int unsigned ghr_len,
                                           input int unsigned idx_w);
        logic [31:0] mask;
        mask = (idx_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << idx_w) - 32'd1);
`ifdef GSHARE_HASH_EN
        return ((pc >> 2) ^ ghr) & mask;
`else
        return (((pc >> 2) << ghr_len) | ghr) & mask;
`endif
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-query / commit-train bus of the direction predictor.
interface gshare_predictor_if #(
    parameter int GHR_LEN = 8
);
    logic               pred_valid;
    logic [31:0]        pred_pc;
    logic               pred_ready;
    logic               pred_taken;
    logic [GHR_LEN-1:0] pred_ghr;
    logic               upd_valid;
    logic [31:0]        upd_pc;
    logic               upd_taken;
    logic [GHR_LEN-1:0] upd_ghr;
    logic               upd_mispredict;

    // Predictor side
    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_ghr, upd_mispredict,
        output pred_ready, pred_taken, pred_ghr
    );

    // Front-end / ROB side
    modport master (
        output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_ghr, upd_mispredict,
        input  pred_ready, pred_taken, pred_ghr
    );
endinterface

// File: rtl/bp_pht_ram.sv
// Pattern history table: async predict read, async update read, one write.
// Both read ports see a same-cycle write, so readers never observe stale data.
module bp_pht_ram #(
    parameter int IDX_W = 8,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_prd_idx,
    output logic [CTR_W-1:0] o_prd_ctr,
    input  logic [IDX_W-1:0] i_upd_idx,
    output logic [CTR_W-1:0] o_upd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [CTR_W-1:0] i_wr_data
);
    logic [CTR_W-1:0] r_mem [2**IDX_W];

    // Counter storage; contents are defined by the init walker, not by reset
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
    end

    assign o_prd_ctr = (i_wr_en && (i_wr_idx == i_prd_idx)) ? i_wr_data : r_mem[i_prd_idx];
    assign o_upd_ctr = (i_wr_en && (i_wr_idx == i_upd_idx)) ? i_wr_data : r_mem[i_upd_idx];
endmodule

// File: rtl/gshare_predictor.sv
// Direction predictor: speculative GHR with recovery, 2-stage PHT training,
// post-reset init walker. Build option GSHARE_HASH_EN selects the hashed index.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int GHR_LEN     = 8,
    parameter int PHT_ENTRIES = 256,
    parameter int CTR_W       = 2,
    parameter int CTR_INIT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    gshare_predictor_if.slave bus
);
    localparam int               IDX_W  = $clog2(PHT_ENTRIES);
    localparam logic [CTR_W-1:0] C_MAX  = CTR_W'(ctr_max(CTR_W));
    localparam logic [CTR_W-1:0] C_THR  = CTR_W'(ctr_thresh(CTR_W));
    localparam logic [CTR_W-1:0] C_INIT = CTR_W'(CTR_INIT);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(PHT_ENTRIES - 1);

    bp_state_e          r_state;
    logic [IDX_W-1:0]   r_walk_idx;
    logic [GHR_LEN-1:0] r_ghr;
    logic               r_u2_vld;
    logic [IDX_W-1:0]   r_u2_idx;
    logic [CTR_W-1:0]   r_u2_ctr;

    logic               w_ready;
    logic [IDX_W-1:0]   w_pred_idx;
    logic [IDX_W-1:0]   w_u1_idx;
    logic [CTR_W-1:0]   w_pred_ctr;
    logic [CTR_W-1:0]   w_u1_ctr;
    logic [CTR_W-1:0]   w_u1_next;
    logic               w_u1_vld;
    logic               w_pred_taken;
    logic               w_wr_en;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [CTR_W-1:0]   w_wr_data;

    // One saturating step; never wraps at either end
    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] c, input logic taken);
        if (taken) return (c == C_MAX) ? c : c + 1'b1;
        else       return (c == '0)    ? c : c - 1'b1;
    endfunction

    assign w_ready      = (r_state == BP_READY);
    assign w_pred_idx   = IDX_W'(bp_idx(bus.pred_pc, 32'(r_ghr), GHR_LEN, IDX_W));
    assign w_u1_idx     = IDX_W'(bp_idx(bus.upd_pc, 32'(bus.upd_ghr), GHR_LEN, IDX_W));
    assign w_pred_taken = bus.pred_valid & w_ready & (w_pred_ctr >= C_THR);
    assign w_u1_vld     = bus.upd_valid & w_ready;
    assign w_u1_next    = sat_step(w_u1_ctr, bus.upd_taken);

    // The walker owns the write port during INIT; U2 never runs then
    assign w_wr_en   = (r_state == BP_INIT) | r_u2_vld;
    assign w_wr_idx  = (r_state == BP_INIT) ? r_walk_idx : r_u2_idx;
    assign w_wr_data = (r_state == BP_INIT) ? C_INIT : r_u2_ctr;

    assign bus.pred_ready = w_ready;
    assign bus.pred_taken = w_pred_taken;
    assign bus.pred_ghr   = r_ghr;

    bp_pht_ram #(.IDX_W(IDX_W), .CTR_W(CTR_W)) u_pht (
        .clk       (clk),
        .i_prd_idx (w_pred_idx),
        .o_prd_ctr (w_pred_ctr),
        .i_upd_idx (w_u1_idx),
        .o_upd_ctr (w_u1_ctr),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (w_wr_data)
    );

    // Control: init walk, speculative history with recovery, U2 valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= BP_INIT;
            r_walk_idx <= '0;
            r_ghr      <= '0;
            r_u2_vld   <= 1'b0;
        end else begin
            r_u2_vld <= w_u1_vld;
            case (r_state)
                BP_INIT: begin
                    r_walk_idx <= r_walk_idx + 1'b1;
                    if (r_walk_idx == C_LAST) r_state <= BP_READY;
                end
                BP_READY: begin
                    if (bus.upd_valid && bus.upd_mispredict)
                        r_ghr <= GHR_LEN'({bus.upd_ghr, bus.upd_taken});
                    else if (bus.pred_valid)
                        r_ghr <= GHR_LEN'({r_ghr, w_pred_taken});
                end
                default: r_state <= BP_INIT;
            endcase
        end
    end

    // U1 -> U2 data capture: index and already-saturated counter value
    always_ff @(posedge clk) begin
        r_u2_idx <= w_u1_idx;
        r_u2_ctr <= w_u1_next;
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: abstract table/history model plus directed
// vectors with hand-computed expectations. Honours GSHARE_HASH_EN.
module tb_gshare_predictor;
    localparam int GHR_LEN = 8;
    localparam int PHT     = 256;
    localparam int CMAX    = 3;
    localparam int CTHR    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    gshare_predictor_if #(.GHR_LEN(GHR_LEN)) bus ();

    gshare_predictor #(.GHR_LEN(GHR_LEN), .PHT_ENTRIES(PHT), .CTR_W(2), .CTR_INIT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: counters, speculative history, ready tracking
    int pht [PHT];
    int mghr;
    int mcnt;
    bit mready;

    function automatic int midx(input logic [31:0] pc, input int g);
        longint p;
        p = longint'(pc >> 2);
`ifdef GSHARE_HASH_EN
        return int'((p ^ longint'(g)) % PHT);
`else
        return int'(((p << GHR_LEN) + longint'(g)) % PHT);
`endif
    endfunction

    function automatic int sat(input int c, input bit t);
        if (t) return (c < CMAX) ? c + 1 : c;
        else   return (c > 0) ? c - 1 : c;
    endfunction

    function automatic bit mtaken();
        return bus.pred_valid && mready && (pht[midx(bus.pred_pc, mghr)] >= CTHR);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: commits take effect at the edge; any predict afterwards sees them
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt   <= 0;
            mready <= 1'b0;
            mghr   <= 0;
            for (int i = 0; i < PHT; i++) pht[i] <= 1;
        end else if (!mready) begin
            mcnt   <= mcnt + 1;
            mready <= (mcnt + 1 == PHT);
        end else begin
            if (bus.upd_valid && bus.upd_mispredict)
                mghr <= ((int'(bus.upd_ghr) * 2) + int'(bus.upd_taken)) % (1 << GHR_LEN);
            else if (bus.pred_valid)
                mghr <= ((mghr * 2) + int'(mtaken())) % (1 << GHR_LEN);
            if (bus.upd_valid)
                pht[midx(bus.upd_pc, int'(bus.upd_ghr))] <=
                    sat(pht[midx(bus.upd_pc, int'(bus.upd_ghr))], bus.upd_taken);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", bus.pred_ready, mready);
            if (mready) begin
                chk("ghr", bus.pred_ghr, mghr);
                chk("taken", bus.pred_taken, mtaken());
            end else begin
                chk("taken_init", bus.pred_taken, 0);
            end
        end
    end

    task automatic idle_in();
        bus.pred_valid = 1'b0; bus.pred_pc = '0;
        bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
        bus.upd_ghr = '0; bus.upd_mispredict = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input int g, input bit t, input bit mis);
        @(posedge clk); #1;
        idle_in();
        bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_ghr = GHR_LEN'(g);
        bus.upd_taken = t; bus.upd_mispredict = mis;
    endtask

    // Force ghr_spec via recovery; the training side effect lands on idx >= 0x80 (concat) / 0x40.. (hash)
    task automatic set_ghr(input int g);
        upd(32'h300, (g >> 1) | 8'h80, g[0], 1'b1);
    endtask

    task automatic pred_chk(input logic [31:0] pc, input bit exp_t, input int exp_g, input string nm);
        @(posedge clk); #1;
        idle_in();
        bus.pred_valid = 1'b1; bus.pred_pc = pc;
        @(negedge clk);
        chk({nm, "_ghr"}, bus.pred_ghr, exp_g);
        chk({nm, "_taken"}, bus.pred_taken, exp_t);
    endtask

    // Release reset and count cycles until ready; drives junk traffic during INIT
    task automatic release_and_count(input string nm);
        int n;
        n = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.pred_valid = 1'b1; bus.pred_pc = 32'h40;
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h40; bus.upd_ghr = '0; bus.upd_taken = 1'b1;
        while (n < 1000) begin
            @(negedge clk);
            if (bus.pred_ready) break;
            n++;
            if (n == 200) idle_in();
        end
        chk(nm, n, 256);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        bus.pred_valid = 1'b1; bus.pred_pc = 32'h40;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.pred_ready, 0);
        chk("rst_taken", bus.pred_taken, 0);
        chk("rst_ghr", bus.pred_ghr, 0);

        release_and_count("init_len");

        pred_chk(32'h40, 1'b0, 0, "post_init_a");
        pred_chk(32'h100, 1'b0, 0, "post_init_b");
        pred_chk(32'hFFC, 1'b0, 0, "post_init_c");

        // Training and saturation at pc 0x40, history 0
        upd(32'h40, 0, 1, 0); upd(32'h40, 0, 1, 0);
        pred_chk(32'h40, 1'b1, 0, "train2");
        set_ghr(0);
        repeat (4) upd(32'h40, 0, 1, 0);
        upd(32'h40, 0, 0, 0);
        pred_chk(32'h40, 1'b1, 0, "sat_hi");
        set_ghr(0);
        repeat (4) upd(32'h40, 0, 0, 0);
        pred_chk(32'h40, 1'b0, 0, "sat_lo_a");
        upd(32'h40, 0, 1, 0);
        pred_chk(32'h40, 1'b0, 0, "sat_lo_b");
        upd(32'h40, 0, 1, 0);
        pred_chk(32'h40, 1'b1, 0, "sat_lo_c");

        // Back-to-back commits to one counter
        repeat (3) upd(32'h80, 5, 1, 0);
        upd(32'h80, 5, 0, 0);
        set_ghr(5);
        pred_chk(32'h80, 1'b1, 5, "b2b");

        // Speculative history and recovery
        set_ghr(0);
        upd(32'h40, 0, 1, 0); upd(32'h40, 0, 1, 0);
        upd(32'h140, 1, 1, 0); upd(32'h140, 1, 1, 0);
        pred_chk(32'h40, 1'b1, 0, "hist0");
        pred_chk(32'h140, 1'b1, 1, "hist1");
        pred_chk(32'h240, 1'b0, 3, "hist2");
        @(posedge clk); #1;
        idle_in();
        bus.pred_valid = 1'b1; bus.pred_pc = 32'h40;
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h340; bus.upd_ghr = 8'h01;
        bus.upd_taken = 1'b0; bus.upd_mispredict = 1'b1;
        @(negedge clk);
        chk("hist3_ghr", bus.pred_ghr, 8'h06);
        pred_chk(32'h40, 1'b0, 8'h02, "recover");

        // Aliasing between (0x44, ghr 1) and (0x40, ghr 0)
        repeat (4) upd(32'h44, 1, 0, 0);
        repeat (4) upd(32'h40, 0, 0, 0);
        upd(32'h40, 0, 1, 0); upd(32'h40, 0, 1, 0);
        set_ghr(1);
`ifdef GSHARE_HASH_EN
        pred_chk(32'h44, 1'b1, 1, "alias");
`else
        pred_chk(32'h44, 1'b0, 1, "alias");
`endif

        // Reset in the middle of the init walk
        @(posedge clk); #1;
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_ready", bus.pred_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midwalk_ready", bus.pred_ready, 0);
        chk("midwalk_ghr", bus.pred_ghr, 0);
        release_and_count("reinit_len");
        pred_chk(32'h40, 1'b0, 0, "reinit");
        pred_chk(32'h140, 1'b0, 0, "reinit_b");

        @(posedge clk); #1;
        idle_in();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
